// File: rtl/divider_pkg.sv
// Shared types and constants for the 8-bit restoring sequential divider.
// Build with SIGNED_DIV_EN defined for two's-complement operands; unsigned otherwise.
package divider_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_ITERS = 8;
    localparam int REM_WIDTH = 10;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement negation, used for magnitudes and sign correction.
    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
        return ~v + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Operand/result bundle of the sequential divider; master requests, slave divides.
interface sequential_divider_if;
    import divider_pkg::*;

    logic                 START;
    logic [DIV_WIDTH-1:0] DIVIDEND;
    logic [DIV_WIDTH-1:0] DIVISOR;
    logic [DIV_WIDTH-1:0] QUOTIENT;
    logic [DIV_WIDTH-1:0] REMAINDER;
    logic                 BUSY;
    logic                 DONE;
    logic                 DIV_ZERO;

    modport master (
        output START, DIVIDEND, DIVISOR,
        input  QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO
    );

    modport slave (
        input  START, DIVIDEND, DIVISOR,
        output QUOTIENT, REMAINDER, BUSY, DONE, DIV_ZERO
    );

endinterface

// File: rtl/div_control_unit.sv
// Divider sequencer: IDLE/ITER/(FIX)/DONE FSM with the iteration counter.
// FIX exists only when SIGNED_DIV_EN is defined.
module div_control_unit
    import divider_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic start,
    input  logic divisor_zero,
    output logic load,
    output logic shift_sub,
`ifdef SIGNED_DIV_EN
    output logic fix,
`endif
    output logic finish,
    output logic busy,
    output logic done
);

    div_state_t state_reg;
    logic [2:0] cnt_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       last_iter;

    assign last_iter = (cnt_reg == 3'(DIV_ITERS - 1));
    assign load      = (state_reg == IDLE) && start;
    assign shift_sub = (state_reg == ITER);
`ifdef SIGNED_DIV_EN
    assign fix       = (state_reg == FIX);
    assign finish    = fix;
`else
    assign finish    = shift_sub && last_iter;
`endif
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg <= '0;
                        if (divisor_zero) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ITER;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (last_iter) begin
`ifdef SIGNED_DIV_EN
                        state_reg <= FIX;
`else
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                FIX: begin
                    state_reg <= DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
`endif
                DONE: begin
                    // Waits for START to drop so a held request cannot retrigger.
                    if (!start) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// 8-bit restoring shift-subtract divider datapath around div_control_unit.
// Define SIGNED_DIV_EN for two's-complement division truncating toward zero.
module sequential_divider
    import divider_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    sequential_divider_if.slave bus
);

    logic                 load, shift_sub, finish, divisor_zero;
    logic [REM_WIDTH-1:0] a_reg, a_shift, trial, a_next;
    logic [DIV_WIDTH-1:0] q_reg, q_shift, q_next, m_reg;
    logic [DIV_WIDTH-1:0] quotient_reg, remainder_reg;
    logic [DIV_WIDTH-1:0] dividend_in, divisor_in, result_q, result_r;
    logic                 div_zero_reg;

    assign divisor_zero = (bus.DIVISOR == '0);

    div_control_unit u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (bus.START),
        .divisor_zero (divisor_zero),
        .load         (load),
        .shift_sub    (shift_sub),
`ifdef SIGNED_DIV_EN
        .fix          (),
`endif
        .finish       (finish),
        .busy         (bus.BUSY),
        .done         (bus.DONE)
    );

    // A stays below 2*M, so its top bit is always zero before the shift.
    assign a_shift = REM_WIDTH'({a_reg, q_reg[DIV_WIDTH-1]});
    assign q_shift = {q_reg[DIV_WIDTH-2:0], 1'b0};
    assign trial   = a_shift - {2'b00, m_reg};
    assign a_next  = trial[REM_WIDTH-1] ? a_shift : trial;
    assign q_next  = q_shift | {{(DIV_WIDTH-1){1'b0}}, ~trial[REM_WIDTH-1]};

`ifdef SIGNED_DIV_EN
    logic neg_q_reg, neg_r_reg;

    assign dividend_in = bus.DIVIDEND[DIV_WIDTH-1] ? negate(bus.DIVIDEND) : bus.DIVIDEND;
    assign divisor_in  = bus.DIVISOR[DIV_WIDTH-1]  ? negate(bus.DIVISOR)  : bus.DIVISOR;
    assign result_q    = neg_q_reg ? negate(q_reg) : q_reg;
    assign result_r    = neg_r_reg ? negate(a_reg[DIV_WIDTH-1:0]) : a_reg[DIV_WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (load) begin
            neg_q_reg <= bus.DIVIDEND[DIV_WIDTH-1] ^ bus.DIVISOR[DIV_WIDTH-1];
            neg_r_reg <= bus.DIVIDEND[DIV_WIDTH-1];
        end
    end
`else
    assign dividend_in = bus.DIVIDEND;
    assign divisor_in  = bus.DIVISOR;
    assign result_q    = q_next;
    assign result_r    = a_next[DIV_WIDTH-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            if (load) begin
                a_reg        <= '0;
                q_reg        <= dividend_in;
                m_reg        <= divisor_in;
                div_zero_reg <= divisor_zero;
                if (divisor_zero) begin
                    quotient_reg  <= DIV_ZERO_QUOT;
                    remainder_reg <= bus.DIVIDEND;
                end
            end
            if (shift_sub) begin
                a_reg <= a_next;
                q_reg <= q_next;
            end
            if (finish) begin
                quotient_reg  <= result_q;
                remainder_reg <= result_r;
            end
        end
    end

    assign bus.QUOTIENT  = quotient_reg;
    assign bus.REMAINDER = remainder_reg;
    assign bus.DIV_ZERO  = div_zero_reg;

endmodule
